pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC enable.
- Handles three hazard classes:
  - load-use data hazards,
  - taken branches resolved in the MEM stage,
  - multi-cycle data-memory accesses, using a request/ready handshake.
- Sits beside the control unit; its outputs gate every pipeline register on the same clk edge.

---
 rtl/pipeline_hazard_ctrl_if.sv | 53 +++++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bus: hazard detection inputs, pipeline register controls, data-memory handshake.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
`timescale 1ns/1ps

interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_memRead;
    logic [4:0]  ex_rd;
    logic        mem_branch;
    logic        mem_zeroFlag;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic        mem_ready;

    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_en;
    logic        exmem_flush;
    logic        mem_req;
    logic        mem_err;
    logic [1:0]  state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    // master: the hazard controller; slave: the pipeline and data memory it steers
    modport master (
`ifdef HAZARD_PERF_EN
        output stall_cycles, output flush_events,
`endif
        input  id_rs, input id_rt, input id_uses_rt, input ex_memRead, input ex_rd,
        input  mem_branch, input mem_zeroFlag, input mem_memRead, input mem_memWrite,
        input  mem_ready,
        output pc_en, output ifid_en, output ifid_flush, output idex_flush,
        output exmem_en, output exmem_flush, output mem_req, output mem_err, output state
    );

    modport slave (
`ifdef HAZARD_PERF_EN
        input  stall_cycles, input flush_events,
`endif
        output id_rs, output id_rt, output id_uses_rt, output ex_memRead, output ex_rd,
        output mem_branch, output mem_zeroFlag, output mem_memRead, output mem_memWrite,
        output mem_ready,
        input  pc_en, input ifid_en, input ifid_flush, input idex_flush,
        input  exmem_en, input exmem_flush, input mem_req, input mem_err, input state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM-stage taken branches, multi-cycle memory.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_events performance counters.
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
    parameter int unsigned BR_FLUSH_CYC = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(BR_FLUSH_CYC - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic memop, taken, lu, taken_evt;
    logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, mem_req;

    always_comb begin
        memop = hz.mem_memRead | hz.mem_memWrite;
        taken = hz.mem_branch & hz.mem_zeroFlag;
        lu    = hz.ex_memRead && (hz.ex_rd != 5'd0) &&
                ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q;
        taken_evt   = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mem_req     = 1'b0;

        unique case (state_q)
            RUN, LOAD_STALL: begin
                state_d = RUN;
                mem_req = memop;
                if (memop && !hz.mem_ready) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    exmem_en   = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = MEM_WAIT;
                end else if (taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    taken_evt   = 1'b1;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
                end else if (lu && state_q == RUN) begin
                    // the dependent instruction holds in ID for exactly one bubble
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    state_d    = LOAD_STALL;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (hz.mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                    if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d >= TIMEOUT) mem_err_d = 1'b1;
                end
            end
            FLUSH: begin
                ifid_flush = 1'b1;
                if (taken) begin
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    taken_evt   = 1'b1;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = '0;
                    state_d     = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase

        // reset freezes the whole pipeline with bubbles, independent of the clock
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            mem_req     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_events_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (!pc_en)    stall_cycles_q <= stall_cycles_q + 32'd1;
            if (taken_evt) flush_events_q <= flush_events_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`endif

    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_en    = exmem_en;
    assign hz.exmem_flush = exmem_flush;
    assign hz.mem_req     = mem_req;
    assign hz.mem_err     = mem_err_q;
    assign hz.state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios, then randomized traffic
// against a behavioural model built from remaining-cycle counts rather than a state machine.
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;

    localparam int BR  = 2;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.BR_FLUSH_CYC(BR), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // model: what the pipeline is waiting on, expressed as remaining work
    bit m_waiting;
    int m_wait_cycles;
    int m_flush_left;
    bit m_stalled;
    bit m_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] m_stalls;
    logic [15:0] m_flushes;
`endif

    bit e_pc, e_ifid, e_exen, e_ifidf, e_idexf, e_exf, e_req;
    bit n_waiting, n_stalled, n_err, n_taken;
    int n_wait_cycles, n_flush_left;

    task automatic model_reset();
        m_waiting = 0; m_wait_cycles = 0; m_flush_left = 0; m_stalled = 0; m_err = 0;
`ifdef HAZARD_PERF_EN
        m_stalls = '0; m_flushes = '0;
`endif
    endtask

    function automatic int exp_state();
        if (m_waiting) return 2;
        if (m_flush_left > 0) return 3;
        if (m_stalled) return 1;
        return 0;
    endfunction

    task automatic model_eval();
        bit memop, taken, lu;
        memop = bus.mem_memRead || bus.mem_memWrite;
        taken = bus.mem_branch && bus.mem_zeroFlag;
        lu    = bus.ex_memRead && bus.ex_rd != 0 &&
                (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
        {e_pc, e_ifid, e_exen} = 3'b111;
        {e_ifidf, e_idexf, e_exf, e_req} = 4'b0000;
        n_waiting = m_waiting; n_wait_cycles = m_wait_cycles; n_flush_left = m_flush_left;
        n_stalled = 0; n_err = m_err; n_taken = 0;
        if (m_waiting) begin
            e_req = 1;
            if (bus.mem_ready) begin
                n_waiting = 0; n_wait_cycles = 0;
            end else begin
                {e_pc, e_ifid, e_exen} = 3'b000;
                n_wait_cycles = (m_wait_cycles < 255) ? m_wait_cycles + 1 : 255;
                if (n_wait_cycles >= TMO) n_err = 1;
            end
        end else if (m_flush_left > 0) begin
            e_ifidf = 1;
            if (taken) begin
                {e_idexf, e_exf} = 2'b11; n_flush_left = BR - 1; n_taken = 1;
            end else begin
                n_flush_left = m_flush_left - 1;
            end
        end else begin
            e_req = memop;
            if (memop && !bus.mem_ready) begin
                {e_pc, e_ifid, e_exen} = 3'b000; n_waiting = 1; n_wait_cycles = 0;
            end else if (taken) begin
                {e_ifidf, e_idexf, e_exf} = 3'b111; n_flush_left = BR - 1; n_taken = 1;
            end else if (lu && !m_stalled) begin
                e_pc = 0; e_ifid = 0; e_idexf = 1; n_stalled = 1;
            end
        end
    endtask

    // inputs already applied: compare mid-cycle, then advance the model across the edge
    task automatic cycle();
        #2;
        model_eval();
        check("pc_en", bus.pc_en, e_pc);
        check("ifid_en", bus.ifid_en, e_ifid);
        check("exmem_en", bus.exmem_en, e_exen);
        check("ifid_flush", bus.ifid_flush, e_ifidf);
        check("idex_flush", bus.idex_flush, e_idexf);
        check("exmem_flush", bus.exmem_flush, e_exf);
        check("mem_req", bus.mem_req, e_req);
        check("mem_err", bus.mem_err, m_err);
        check("state", bus.state, exp_state());
`ifdef HAZARD_PERF_EN
        check("stall_cycles", bus.stall_cycles, m_stalls);
        check("flush_events", bus.flush_events, m_flushes);
`endif
        @(posedge clk);
`ifdef HAZARD_PERF_EN
        if (!e_pc) m_stalls = m_stalls + 32'd1;
        if (n_taken) m_flushes = m_flushes + 16'd1;
`endif
        m_waiting = n_waiting; m_wait_cycles = n_wait_cycles; m_flush_left = n_flush_left;
        m_stalled = n_stalled; m_err = n_err;
        #1;
    endtask

    task automatic idle();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.ex_memRead = 0; bus.ex_rd = '0;
        bus.mem_branch = 0; bus.mem_zeroFlag = 0; bus.mem_memRead = 0; bus.mem_memWrite = 0;
        bus.mem_ready = 0;
    endtask

    task automatic set_random();
        bus.id_rs        = 5'($urandom_range(0, 3));
        bus.id_rt        = 5'($urandom_range(0, 3));
        bus.ex_rd        = 5'($urandom_range(0, 3));
        bus.id_uses_rt   = 1'($urandom_range(0, 1));
        bus.ex_memRead   = ($urandom_range(0, 2) == 0);
        bus.mem_branch   = ($urandom_range(0, 3) == 0);
        bus.mem_zeroFlag = 1'($urandom_range(0, 1));
        bus.mem_memRead  = ($urandom_range(0, 7) == 0);
        bus.mem_memWrite = ($urandom_range(0, 9) == 0);
        bus.mem_ready    = 1'($urandom_range(0, 1));
    endtask

    // asserts reset mid-cycle, checks the frozen outputs before any edge, holds two edges
    task automatic do_reset();
        #3;
        reset = 1;
        #1;
        model_reset();
        check("rst_pc_en", bus.pc_en, 0);
        check("rst_ifid_en", bus.ifid_en, 0);
        check("rst_exmem_en", bus.exmem_en, 0);
        check("rst_flushes", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 3'b111);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_state", bus.state, 0);
        check("rst_mem_err", bus.mem_err, 0);
`ifdef HAZARD_PERF_EN
        check("rst_stall_cycles", bus.stall_cycles, 0);
        check("rst_flush_events", bus.flush_events, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        do_reset();

        // load-use on rs: one stall, then the held instruction proceeds
        idle(); bus.ex_memRead = 1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
        cycle(); check("lu_state_stall", bus.state, 1);
        cycle(); check("lu_state_back", bus.state, 0);
        bus.ex_rd = 5'd0;
        cycle(); check("lu_rd0_state", bus.state, 0);

        // rt dependency only counts when the instruction reads rt
        idle(); bus.ex_memRead = 1; bus.ex_rd = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd1;
        cycle(); check("rt_unused_state", bus.state, 0);
        bus.id_uses_rt = 1;
        cycle(); check("rt_used_state", bus.state, 1);
        idle(); cycle();

        // three-cycle memory wait, released on the ready cycle
        idle(); bus.mem_memRead = 1;
        repeat (3) cycle();
        check("mw_state_wait", bus.state, 2);
        bus.mem_ready = 1;
        cycle(); check("mw_state_done", bus.state, 0);
        idle();
`ifdef HAZARD_PERF_EN
        check("perf_stalls_5", bus.stall_cycles, 5);
`endif

        // taken branch wins over a simultaneous load-use
        idle(); bus.mem_branch = 1; bus.mem_zeroFlag = 1;
        bus.ex_memRead = 1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
        cycle(); check("br_state_flush", bus.state, 3);
        idle();
        cycle(); check("br_state_run", bus.state, 0);
`ifdef HAZARD_PERF_EN
        check("perf_flush_1", bus.flush_events, 1);
`endif

        // memory timeout: sticky error, cleared only by an asynchronous reset
        idle(); bus.mem_memWrite = 1;
        repeat (6) cycle();
        check("tmo_err_set", bus.mem_err, 1);
        bus.mem_ready = 1;
        cycle();
        idle();
        cycle(); check("tmo_err_sticky", bus.mem_err, 1);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                idle();
                do_reset();
            end
            set_random();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
